// File: rtl/cpu_mem_pkg.sv
// Shared types for the instruction/data memory arbiter: FSM state encoding,
// grant identifiers and the RISC-V NOP returned on instruction fetch timeouts.
package cpu_mem_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        BUSY_I = 2'd1,
        BUSY_D = 2'd2
    } arb_state_t;

    typedef enum logic {
        GNT_I = 1'b0,
        GNT_D = 1'b1
    } grant_t;

    localparam logic [31:0] RV_NOP = 32'h00000013;

endpackage

// File: rtl/mem_arb_watchdog.sv
// Busy-cycle counter for the arbiter; expired flags the terminal count so a
// memory that never answers cannot stall the core. TIMEOUT_CYCLES=0 disables it.
module mem_arb_watchdog #(
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic clock,
    input  logic reset,
    input  logic clear,
    input  logic enable,
    output logic expired
);

    localparam int CW = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam logic [CW-1:0] TERM = (TIMEOUT_CYCLES > 0) ? CW'(TIMEOUT_CYCLES - 1) : '0;

    logic [CW-1:0] count;

    // Hold at the terminal count; the arbiter leaves BUSY that same cycle anyway.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            count <= '0;
        end else if (clear) begin
            count <= '0;
        end else if (enable && !expired) begin
            count <= count + CW'(1);
        end
    end

    assign expired = (TIMEOUT_CYCLES != 0) && (count == TERM);

endmodule

// File: rtl/mem_arbiter.sv
// Round-robin arbiter sharing one single-port memory between instruction fetch
// (read-only) and load/store. One transaction in flight; responses go to the owner.
module mem_arbiter
    import cpu_mem_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic        clock,
    input  logic        reset,
    input  logic [31:0] i_addr,
    input  logic        i_valid,
    output logic        i_ready,
    output logic [31:0] i_rdata,
    output logic        i_err,
    input  logic [31:0] d_addr,
    input  logic [31:0] d_wdata,
    input  logic [3:0]  d_wstrb,
    input  logic        d_we,
    input  logic        d_valid,
    output logic        d_ready,
    output logic [31:0] d_rdata,
    output logic        d_err,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    output logic [3:0]  mem_wstrb,
    output logic        mem_we,
    output logic        mem_valid,
    input  logic [31:0] mem_rdata,
    input  logic        mem_ready
);

    arb_state_t state;
    grant_t     last_grant;
    logic       expired;
    logic       done;
    logic       grant_i;

    mem_arb_watchdog #(.TIMEOUT_CYCLES(TIMEOUT_CYCLES)) u_watchdog (
        .clock   (clock),
        .reset   (reset),
        .clear   (state == IDLE),
        .enable  ((state != IDLE) && !mem_ready),
        .expired (expired)
    );

    // A completing mem_ready beats a simultaneous watchdog expiry.
    assign done    = mem_ready || expired;
    assign grant_i = i_valid && (!d_valid || (last_grant == GNT_D));

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state      <= IDLE;
            last_grant <= GNT_D;
            mem_addr   <= '0;
            mem_wdata  <= '0;
            mem_wstrb  <= '0;
            mem_we     <= 1'b0;
            mem_valid  <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (grant_i) begin
                        state     <= BUSY_I;
                        mem_addr  <= i_addr;
                        mem_wdata <= '0;
                        mem_wstrb <= 4'b0000;
                        mem_we    <= 1'b0;
                        mem_valid <= 1'b1;
                    end else if (d_valid) begin
                        state     <= BUSY_D;
                        mem_addr  <= d_addr;
                        mem_wdata <= d_wdata;
                        mem_wstrb <= d_we ? d_wstrb : 4'b0000;
                        mem_we    <= d_we;
                        mem_valid <= 1'b1;
                    end
                end
                BUSY_I: begin
                    if (done) begin
                        state      <= IDLE;
                        last_grant <= GNT_I;
                        mem_valid  <= 1'b0;
                    end
                end
                BUSY_D: begin
                    if (done) begin
                        state      <= IDLE;
                        last_grant <= GNT_D;
                        mem_valid  <= 1'b0;
                    end
                end
                default: begin
                    state     <= IDLE;
                    mem_valid <= 1'b0;
                end
            endcase
        end
    end

    assign i_ready = (state == BUSY_I) && done;
    assign i_err   = (state == BUSY_I) && !mem_ready && expired;
    assign i_rdata = ((state == BUSY_I) && mem_ready) ? mem_rdata : RV_NOP;

    assign d_ready = (state == BUSY_D) && done;
    assign d_err   = (state == BUSY_D) && !mem_ready && expired;
    assign d_rdata = ((state == BUSY_D) && mem_ready) ? mem_rdata : 32'h0;

endmodule

// File: tb/tb_mem_arbiter.sv
// Bench for mem_arbiter: directed vector table, contention and reset sequences,
// then random traffic compared against a transaction-level reference model.
module tb_mem_arbiter;

    localparam int TO = 4;
    localparam logic [31:0] NOP = 32'h00000013;

    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic [31:0] i_addr = '0;
    logic        i_valid = 1'b0;
    logic        i_ready;
    logic [31:0] i_rdata;
    logic        i_err;
    logic [31:0] d_addr = '0;
    logic [31:0] d_wdata = '0;
    logic [3:0]  d_wstrb = '0;
    logic        d_we = 1'b0;
    logic        d_valid = 1'b0;
    logic        d_ready;
    logic [31:0] d_rdata;
    logic        d_err;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [3:0]  mem_wstrb;
    logic        mem_we;
    logic        mem_valid;
    logic [31:0] mem_rdata = '0;
    logic        mem_ready = 1'b0;

    int n_checks = 0;
    int n_fail   = 0;

    mem_arbiter #(.TIMEOUT_CYCLES(TO)) dut (
        .clock(clock), .reset(reset),
        .i_addr(i_addr), .i_valid(i_valid), .i_ready(i_ready), .i_rdata(i_rdata), .i_err(i_err),
        .d_addr(d_addr), .d_wdata(d_wdata), .d_wstrb(d_wstrb), .d_we(d_we), .d_valid(d_valid),
        .d_ready(d_ready), .d_rdata(d_rdata), .d_err(d_err),
        .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_wstrb(mem_wstrb), .mem_we(mem_we),
        .mem_valid(mem_valid), .mem_rdata(mem_rdata), .mem_ready(mem_ready)
    );

    always #5 clock = ~clock;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic next_cycle();
        @(posedge clock);
        #1;
    endtask

    task automatic drive(input logic iv, input logic [31:0] ia, input logic dv, input logic dwe,
                         input logic [31:0] da, input logic [31:0] dwd, input logic [3:0] dst,
                         input logic mr, input logic [31:0] mrd);
        i_valid = iv; i_addr = ia;
        d_valid = dv; d_we = dwe; d_addr = da; d_wdata = dwd; d_wstrb = dst;
        mem_ready = mr; mem_rdata = mrd;
    endtask

    task automatic apply_reset();
        next_cycle();
        reset = 1'b1;
        drive(0, 0, 0, 0, 0, 0, 0, 0, 0);
        next_cycle();
        reset = 1'b0;
    endtask

    typedef struct {
        logic iv; logic [31:0] ia;
        logic dv; logic dwe; logic [31:0] da; logic [31:0] dwd; logic [3:0] dst;
        logic mr; logic [31:0] mrd;
        logic e_mv; logic [31:0] e_ma; logic e_we; logic [31:0] e_wd; logic [3:0] e_st;
        logic e_ir; logic e_ie; logic [31:0] e_ird;
        logic e_dr; logic e_de; logic [31:0] e_drd;
    } vec_t;

    function automatic vec_t vec(
        input logic iv, input logic [31:0] ia,
        input logic dv, input logic dwe, input logic [31:0] da, input logic [31:0] dwd, input logic [3:0] dst,
        input logic mr, input logic [31:0] mrd,
        input logic e_mv, input logic [31:0] e_ma, input logic e_we, input logic [31:0] e_wd, input logic [3:0] e_st,
        input logic e_ir, input logic e_ie, input logic [31:0] e_ird,
        input logic e_dr, input logic e_de, input logic [31:0] e_drd);
        vec_t v;
        v.iv = iv; v.ia = ia; v.dv = dv; v.dwe = dwe; v.da = da; v.dwd = dwd; v.dst = dst;
        v.mr = mr; v.mrd = mrd;
        v.e_mv = e_mv; v.e_ma = e_ma; v.e_we = e_we; v.e_wd = e_wd; v.e_st = e_st;
        v.e_ir = e_ir; v.e_ie = e_ie; v.e_ird = e_ird;
        v.e_dr = e_dr; v.e_de = e_de; v.e_drd = e_drd;
        return v;
    endfunction

    vec_t tbl[$];
    int   got_q[$];

    // Reference model state: who owns the memory and how long it has waited.
    int          m_owner;
    int          m_waited;
    int          m_last;
    logic [31:0] m_addr;
    logic [31:0] m_wdata;
    logic [3:0]  m_strb;
    logic        m_we;

    initial begin
        // Reset values while reset is held from time 0.
        #2;
        check("rst_mem_valid", 32'(mem_valid), 0);
        check("rst_mem_addr",  mem_addr, 0);
        check("rst_mem_wdata", mem_wdata, 0);
        check("rst_mem_wstrb", 32'(mem_wstrb), 0);
        check("rst_mem_we",    32'(mem_we), 0);
        check("rst_i_ready",   32'(i_ready), 0);
        check("rst_i_err",     32'(i_err), 0);
        check("rst_i_rdata",   i_rdata, NOP);
        check("rst_d_ready",   32'(d_ready), 0);
        check("rst_d_err",     32'(d_err), 0);
        check("rst_d_rdata",   d_rdata, 0);
        next_cycle();
        reset = 1'b0;

        // Single read, store with 3 waits (completes on the terminal count),
        // data read timeout, instruction fetch timeout.
        tbl.push_back(vec(1, 'h100, 0, 0, 0, 0, 0, 0, 0,                     0, 0, 0, 0, 0, 0, 0, NOP, 0, 0, 0));
        tbl.push_back(vec(0, 0, 0, 0, 0, 0, 0, 1, 'hDEADBEEF,                1, 'h100, 0, 0, 0, 1, 0, 'hDEADBEEF, 0, 0, 0));
        tbl.push_back(vec(0, 0, 0, 0, 0, 0, 0, 0, 0,                         0, 0, 0, 0, 0, 0, 0, NOP, 0, 0, 0));
        tbl.push_back(vec(0, 0, 1, 1, 'h2004, 'h12345678, 4'b0011, 0, 0,     0, 0, 0, 0, 0, 0, 0, NOP, 0, 0, 0));
        for (int k = 0; k < 3; k++)
            tbl.push_back(vec(0, 0, 1, 1, 'h2004, 'h12345678, 4'b0011, 0, 'h77777777,
                              1, 'h2004, 1, 'h12345678, 4'b0011, 0, 0, NOP, 0, 0, 0));
        tbl.push_back(vec(0, 0, 1, 1, 'h2004, 'h12345678, 4'b0011, 1, 'hAAAA5555,
                          1, 'h2004, 1, 'h12345678, 4'b0011, 0, 0, NOP, 1, 0, 'hAAAA5555));
        tbl.push_back(vec(0, 0, 0, 0, 0, 0, 0, 0, 0,                         0, 0, 0, 0, 0, 0, 0, NOP, 0, 0, 0));
        tbl.push_back(vec(0, 0, 1, 0, 'h3000, 'hFFFFFFFF, 4'hF, 0, 0,        0, 0, 0, 0, 0, 0, 0, NOP, 0, 0, 0));
        for (int k = 0; k < 3; k++)
            tbl.push_back(vec(0, 0, 1, 0, 'h3000, 'hFFFFFFFF, 4'hF, 0, 'h5A5A5A5A,
                              1, 'h3000, 0, 0, 4'h0, 0, 0, NOP, 0, 0, 0));
        tbl.push_back(vec(0, 0, 1, 0, 'h3000, 'hFFFFFFFF, 4'hF, 0, 'h5A5A5A5A,
                          1, 'h3000, 0, 0, 4'h0, 0, 0, NOP, 1, 1, 0));
        tbl.push_back(vec(0, 0, 0, 0, 0, 0, 0, 0, 0,                         0, 0, 0, 0, 0, 0, 0, NOP, 0, 0, 0));
        tbl.push_back(vec(1, 'h400, 0, 0, 0, 0, 0, 0, 0,                     0, 0, 0, 0, 0, 0, 0, NOP, 0, 0, 0));
        for (int k = 0; k < 3; k++)
            tbl.push_back(vec(1, 'h400, 0, 0, 0, 0, 0, 0, 'hCAFEF00D,
                              1, 'h400, 0, 0, 4'h0, 0, 0, NOP, 0, 0, 0));
        tbl.push_back(vec(1, 'h400, 0, 0, 0, 0, 0, 0, 'hCAFEF00D,            1, 'h400, 0, 0, 4'h0, 1, 1, NOP, 0, 0, 0));
        tbl.push_back(vec(0, 0, 0, 0, 0, 0, 0, 0, 0,                         0, 0, 0, 0, 0, 0, 0, NOP, 0, 0, 0));

        foreach (tbl[n]) begin
            vec_t v;
            v = tbl[n];
            drive(v.iv, v.ia, v.dv, v.dwe, v.da, v.dwd, v.dst, v.mr, v.mrd);
            #4;
            check($sformatf("vec%0d_mem_valid", n), 32'(mem_valid), 32'(v.e_mv));
            check($sformatf("vec%0d_i_ready", n), 32'(i_ready), 32'(v.e_ir));
            check($sformatf("vec%0d_i_err", n), 32'(i_err), 32'(v.e_ie));
            check($sformatf("vec%0d_i_rdata", n), i_rdata, v.e_ird);
            check($sformatf("vec%0d_d_ready", n), 32'(d_ready), 32'(v.e_dr));
            check($sformatf("vec%0d_d_err", n), 32'(d_err), 32'(v.e_de));
            check($sformatf("vec%0d_d_rdata", n), d_rdata, v.e_drd);
            if (v.e_mv) begin
                check($sformatf("vec%0d_mem_addr", n), mem_addr, v.e_ma);
                check($sformatf("vec%0d_mem_we", n), 32'(mem_we), 32'(v.e_we));
                check($sformatf("vec%0d_mem_wstrb", n), 32'(mem_wstrb), 32'(v.e_st));
                if (v.e_we) check($sformatf("vec%0d_mem_wdata", n), mem_wdata, v.e_wd);
            end
            next_cycle();
        end

        // Contention from reset: both requesters always valid, zero-wait memory.
        apply_reset();
        drive(1, 'h500, 1, 0, 'h600, 0, 0, 1, 'h11112222);
        for (int c = 0; c < 16; c++) begin
            #4;
            if (i_ready && d_ready) check("cont_both_ready", 1, 0);
            if (i_ready) got_q.push_back(0);
            if (d_ready) got_q.push_back(1);
            next_cycle();
        end
        check("cont_count", got_q.size(), 8);
        foreach (got_q[k]) check($sformatf("cont_order%0d", k), got_q[k], k % 2);

        // Reset in the middle of a data transaction; afterwards a tie must go to I.
        apply_reset();
        drive(1, 'h700, 0, 0, 0, 0, 0, 1, 'h1);
        next_cycle();
        #4;
        check("mid_pre_i_ready", 32'(i_ready), 1);
        next_cycle();
        drive(0, 0, 1, 1, 'h800, 'h55, 4'hF, 0, 0);
        next_cycle();
        #4;
        check("mid_busy_d_valid", 32'(mem_valid), 1);
        #1;
        mem_ready = 1'b1;
        reset = 1'b1;
        #1;
        check("mid_rst_mem_valid", 32'(mem_valid), 0);
        check("mid_rst_d_ready", 32'(d_ready), 0);
        check("mid_rst_i_ready", 32'(i_ready), 0);
        check("mid_rst_d_rdata", d_rdata, 0);
        check("mid_rst_i_rdata", i_rdata, NOP);
        check("mid_rst_mem_we", 32'(mem_we), 0);
        next_cycle();
        reset = 1'b0;
        drive(1, 'h900, 1, 0, 'hA00, 0, 0, 0, 0);
        next_cycle();
        mem_ready = 1'b1;
        mem_rdata = 'hBEEF0001;
        #4;
        check("mid_after_mem_addr", mem_addr, 'h900);
        check("mid_after_i_ready", 32'(i_ready), 1);
        check("mid_after_i_rdata", i_rdata, 'hBEEF0001);
        check("mid_after_d_ready", 32'(d_ready), 0);

        // Random traffic against the reference model.
        apply_reset();
        m_owner = -1; m_waited = 0; m_last = 1;
        m_addr = '0; m_wdata = '0; m_strb = '0; m_we = 1'b0;
        for (int c = 0; c < 600; c++) begin
            logic done_e, err_e;
            drive(($urandom_range(0, 9) < 7), $urandom, ($urandom_range(0, 9) < 5), $urandom_range(0, 1),
                  $urandom, $urandom, 4'($urandom_range(0, 15)), ($urandom_range(0, 9) < 3), $urandom);
            #4;
            done_e = (m_owner >= 0) && (mem_ready || (m_waited == TO - 1));
            err_e  = (m_owner >= 0) && !mem_ready && (m_waited == TO - 1);
            check("rnd_mem_valid", 32'(mem_valid), 32'(m_owner >= 0));
            check("rnd_i_ready", 32'(i_ready), 32'(done_e && m_owner == 0));
            check("rnd_i_err", 32'(i_err), 32'(err_e && m_owner == 0));
            check("rnd_i_rdata", i_rdata, (m_owner == 0 && mem_ready) ? mem_rdata : NOP);
            check("rnd_d_ready", 32'(d_ready), 32'(done_e && m_owner == 1));
            check("rnd_d_err", 32'(d_err), 32'(err_e && m_owner == 1));
            check("rnd_d_rdata", d_rdata, (m_owner == 1 && mem_ready) ? mem_rdata : 0);
            if (m_owner >= 0) begin
                check("rnd_mem_addr", mem_addr, m_addr);
                check("rnd_mem_we", 32'(mem_we), 32'(m_we));
                check("rnd_mem_wstrb", 32'(mem_wstrb), 32'(m_strb));
                if (m_we) check("rnd_mem_wdata", mem_wdata, m_wdata);
            end
            if (m_owner < 0) begin
                if (i_valid && (!d_valid || m_last == 1)) begin
                    m_owner = 0; m_addr = i_addr; m_we = 0; m_strb = 0;
                end else if (d_valid) begin
                    m_owner = 1; m_addr = d_addr; m_we = d_we; m_wdata = d_wdata;
                    m_strb = d_we ? d_wstrb : 4'b0000;
                end
                m_waited = 0;
            end else if (done_e) begin
                m_last = m_owner;
                m_owner = -1;
            end else begin
                m_waited++;
            end
            next_cycle();
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/mem_arbiter.md
# mem_arbiter

Two-requester arbiter sharing one AXI-like single-port memory between the instruction fetch unit (read-only port) and the load/store path (read/write port). Grants one transaction at a time, keeps address, write data and strobes stable to memory until completion, and routes the response back to the owner. Ties are resolved round-robin. A watchdog ends a stalled transaction with an error so the core cannot hang.

## Interface
- TIMEOUT_CYCLES, 255: mem_valid cycles without mem_ready before abort; 0 disables the watchdog.
- clock  in  1  system clock, rising edge.
- reset  in  1  asynchronous, active-high.
- i_addr  in  32  instruction fetch address.
- i_valid  in  1  instruction request.
- i_ready  out  1  instruction transaction complete (one-cycle pulse).
- i_rdata  out  32  instruction word; valid only while i_ready=1.
- i_err  out  1  instruction timeout, qualified by i_ready.
- d_addr  in  32  data address.
- d_wdata  in  32  store data.
- d_wstrb  in  4  byte strobes; ignored on reads.
- d_we  in  1  1 = write, 0 = read.
- d_valid  in  1  data request.
- d_ready  out  1  data transaction complete (one-cycle pulse).
- d_rdata  out  32  load data; valid only while d_ready=1.
- d_err  out  1  data timeout, qualified by d_ready.
- mem_addr  out  32  registered memory address.
- mem_wdata  out  32  registered store data.
- mem_wstrb  out  4  registered strobes; 4'b0000 on reads.
- mem_we  out  1  registered write enable.
- mem_valid  out  1  request to memory.
- mem_rdata  in  32  memory read data.
- mem_ready  in  1  memory completion.

## Operation
- States: IDLE, BUSY_I, BUSY_D.
- IDLE: mem_valid=0.
  - i_valid only → latch i_addr, set mem_we=0 and mem_wstrb=0, go to BUSY_I.
  - d_valid only → latch d_addr, d_wdata, d_wstrb and d_we, go to BUSY_D.
  - Both → grant the port that was not granted last. The last_grant register resets to D, so I wins the first tie.
- BUSY_x: mem_valid=1, and all mem_* request outputs stay constant.
  - On mem_ready=1: x_ready=1 in the same cycle, x_rdata=mem_rdata combinationally, x_err=0. Return to IDLE at the next edge. last_grant←x.
- Watchdog: counter cleared on entry to BUSY_x and incremented each BUSY cycle without mem_ready.
  - When the count reaches TIMEOUT_CYCLES-1 and mem_ready=0: x_ready=1 and x_err=1, then go to IDLE.
  - On timeout, i_rdata=32'h00000013 (NOP) and d_rdata=32'h0.
  - mem_ready in the same cycle as the timeout has priority, so the transaction completes normally with no error.
- Requester drops valid mid-transaction: the memory transaction still completes. The ready pulse is still generated.
- Ready pulses go only to the owner. The non-owner ready is always 0.
- Reset (at any time, including mid-transaction): state=IDLE, last_grant=D, counter=0. All outputs go to 0, except i_rdata, which is 32'h00000013 whenever i_ready=0.

## Timing
- Request seen in IDLE at cycle N → mem_valid=1 from cycle N+1.
- With zero-wait memory (mem_ready=1 at N+1), x_ready=1 at N+1.
- Minimum latency 1 cycle. Maximum throughput 1 transaction per 2 cycles, because IDLE costs one cycle.
- A requester that keeps valid high after its ready pulse is treated as a new request in the following IDLE cycle.
  - The IFU keeps valid high permanently. Round-robin therefore interleaves I and D under contention, and each port gets at least one grant every 2 transactions.
- No combinational path from mem_ready or mem_rdata to any mem_* output. x_ready, x_rdata and x_err are combinational from mem_ready and mem_rdata.

## Structure
- Package cpu_mem_pkg holds:
  - state encoding (IDLE=2'd0, BUSY_I=2'd1, BUSY_D=2'd2);
  - grant ids (GNT_I, GNT_D);
  - RV_NOP=32'h00000013.
- One natural sub-module, mem_arb_watchdog: counter plus terminal-count compare, parameterised by TIMEOUT_CYCLES, with inputs clear/enable and output expired.
- The FSM, the round-robin logic and the request registers stay in mem_arbiter.

## Test plan
- Single read: i_valid=1, i_addr=0x100, and mem returns 0xDEADBEEF with ready in the first mem_valid cycle → mem_addr=0x100, mem_we=0, i_ready pulses once with i_rdata=0xDEADBEEF, d_ready stays 0.
- Store: d_we=1, d_addr=0x2004, d_wdata=0x12345678, d_wstrb=4'b0011, and mem_ready after 3 wait cycles → the mem_* fields are stable for all 4 mem_valid cycles, then d_ready pulses once with d_err=0.
- Contention: i_valid and d_valid held high for 8 transactions from reset → grant order I,D,I,D,… and each requester receives 4 ready pulses.
- Timeout: TIMEOUT_CYCLES=4, data read, mem_ready never asserted → d_ready=1 and d_err=1 in the 4th mem_valid cycle, d_rdata=0, then IDLE.
- Timeout boundary: mem_ready asserted exactly in the terminal-count cycle → normal completion with err=0.
- Reset mid-operation: reset asserted during BUSY_D with mem_valid=1 → mem_valid=0 and all ready outputs 0 immediately. After release, a simultaneous I and D request grants I first.
